// File: rtl/floo_clint_ctrl.sv
// Core-local interruptor: per-core msip bits, prescaled 64-bit mtime and per-core mtimecmp
// comparators driving mtip, behind a single-outstanding 32-bit request/response register port.
module floo_clint_ctrl #(
  parameter int unsigned NumCores  = 9,
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned RtcDivide = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_wstrb_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic [NumCores-1:0]  msip_o,
  output logic [NumCores-1:0]  mtip_o
);

  localparam int unsigned PW = (RtcDivide > 1) ? $clog2(RtcDivide) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(RtcDivide - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t              r_state, w_state_next;
  logic [NumCores-1:0] r_msip, r_mtip;
  logic [63:0]         r_mtimecmp [NumCores];
  logic [63:0]         r_mtime;
  logic [PW-1:0]       r_presc;
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_error;

  logic [31:0]         w_off;
  logic                w_acc, w_we, w_tick, w_hit;
  logic                w_mtime_lo_sel, w_mtime_hi_sel;
  logic [NumCores-1:0] w_msip_sel, w_cmp_lo_sel, w_cmp_hi_sel;
  logic [NumCores-1:0] w_msip_next, w_mtip_next;
  logic [63:0]         w_cmp_next [NumCores];
  logic [63:0]         w_mtime_inc, w_mtime_next;
  logic [31:0]         w_rdata;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  assign w_off  = 32'(req_addr_i) & 32'hFFFF_FFFC;
  assign w_acc  = req_valid_i && (r_state == IDLE);
  assign w_we   = w_acc && req_write_i;
  assign w_tick = (r_presc == PRESC_MAX);

  assign w_mtime_lo_sel = (w_off == 32'h0000_BFF8);
  assign w_mtime_hi_sel = (w_off == 32'h0000_BFFC);
  assign w_hit = (|w_msip_sel) || (|w_cmp_lo_sel) || (|w_cmp_hi_sel)
              || w_mtime_lo_sel || w_mtime_hi_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NumCores; gi++) begin : g_core
      assign w_msip_sel[gi]   = (w_off == 32'(4 * gi));
      assign w_cmp_lo_sel[gi] = (w_off == 32'h0000_4000 + 32'(8 * gi));
      assign w_cmp_hi_sel[gi] = (w_off == 32'h0000_4004 + 32'(8 * gi));

      assign w_msip_next[gi] = (w_we && w_msip_sel[gi] && req_wstrb_i[0]) ? req_wdata_i[0]
                                                                          : r_msip[gi];
      assign w_cmp_next[gi][63:32] = (w_we && w_cmp_hi_sel[gi])
          ? f_merge(r_mtimecmp[gi][63:32], req_wdata_i, req_wstrb_i) : r_mtimecmp[gi][63:32];
      assign w_cmp_next[gi][31:0]  = (w_we && w_cmp_lo_sel[gi])
          ? f_merge(r_mtimecmp[gi][31:0], req_wdata_i, req_wstrb_i) : r_mtimecmp[gi][31:0];
      // Compare registered values so mtip lags any register update by one cycle.
      assign w_mtip_next[gi] = (r_mtime >= r_mtimecmp[gi]);
    end
  endgenerate

  // Written bytes win over a same-cycle tick; unwritten bytes keep the incremented value.
  assign w_mtime_inc = r_mtime + 64'(w_tick);
  always_comb begin
    w_mtime_next = w_mtime_inc;
    if (w_we && w_mtime_lo_sel)
      w_mtime_next[31:0] = f_merge(w_mtime_inc[31:0], req_wdata_i, req_wstrb_i);
    if (w_we && w_mtime_hi_sel)
      w_mtime_next[63:32] = f_merge(w_mtime_inc[63:32], req_wdata_i, req_wstrb_i);
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NumCores; i++) begin
      if (w_msip_sel[i])   w_rdata = {31'b0, r_msip[i]};
      if (w_cmp_lo_sel[i]) w_rdata = r_mtimecmp[i][31:0];
      if (w_cmp_hi_sel[i]) w_rdata = r_mtimecmp[i][63:32];
    end
    if (w_mtime_lo_sel) w_rdata = r_mtime[31:0];
    if (w_mtime_hi_sel) w_rdata = r_mtime[63:32];
  end

  always_comb begin
    w_state_next = r_state;
    req_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_state_next = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_msip      <= '0;
      r_mtip      <= '0;
      r_mtime     <= '0;
      r_presc     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      for (int i = 0; i < NumCores; i++) r_mtimecmp[i] <= '1;
    end else begin
      r_state <= w_state_next;
      r_msip  <= w_msip_next;
      r_mtip  <= w_mtip_next;
      r_mtime <= w_mtime_next;
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      for (int i = 0; i < NumCores; i++) r_mtimecmp[i] <= w_cmp_next[i];
      if (w_acc) begin
        r_rsp_rdata <= (req_write_i || !w_hit) ? 32'h0 : w_rdata;
        r_rsp_error <= !w_hit;
      end
    end
  end

  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_error_o = r_rsp_error;
  assign msip_o      = r_msip;
  assign mtip_o      = r_mtip;

endmodule
